// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared opcodes, NOP word and fetch-stage state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [4:0]  c_OP_NOP   = 5'b00000;
    localparam logic [4:0]  c_OP_HALT  = 5'b00001;
    localparam logic [15:0] c_NOP_WORD = {c_OP_NOP, 11'd0};

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_t;

    function automatic logic is_halt_op(input logic [4:0] opcode);
        return opcode == c_OP_HALT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage: PC, IF/ID register, start/stall/
//               branch-flush handling and HALT detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              IR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_addr,
    output logic [PC_W-1:0] addr,
    input  logic [IR_W-1:0] iout,
    output logic [IR_W-1:0] id_ir,
    output logic [PC_W-1:0] id_pc,
    output logic            halted,
    output logic            running
);

    localparam logic [IR_W-1:0] c_NOP = IR_W'(c_NOP_WORD);

    if_state_t       r_state;
    if_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [IR_W-1:0] r_id_ir;
    logic [IR_W-1:0] w_id_ir_nxt;
    logic [PC_W-1:0] r_id_pc;
    logic [PC_W-1:0] w_id_pc_nxt;
    logic            w_fetch_halt;

    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_fetch_halt = is_halt_op(iout[IR_W-1 -: 5]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IF_IDLE;
            r_pc    <= RESET_PC;
            r_id_ir <= c_NOP;
            r_id_pc <= '0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_id_ir <= w_id_ir_nxt;
            r_id_pc <= w_id_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_id_ir_nxt = r_id_ir;
        w_id_pc_nxt = r_id_pc;
        case (r_state)
            IF_IDLE: begin
                w_id_ir_nxt = c_NOP;
                if (start) begin
                    w_state_nxt = IF_RUN;
                    w_pc_nxt    = RESET_PC;
                end
            end
            IF_RUN: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_addr;
                    w_id_ir_nxt = c_NOP;
                    w_id_pc_nxt = '0;
                end else if (!stall) begin
                    w_id_ir_nxt = iout;
                    w_id_pc_nxt = w_pc_inc;
                    // The HALT word still enters decode; only the PC stops here.
                    if (w_fetch_halt) begin
                        w_state_nxt = IF_HALT;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            IF_HALT: begin
                w_id_ir_nxt = c_NOP;
                if (branch_taken) begin
                    w_state_nxt = IF_RUN;
                    w_pc_nxt    = branch_addr;
                    w_id_pc_nxt = '0;
                end else if (start) begin
                    w_state_nxt = IF_RUN;
                    w_pc_nxt    = RESET_PC;
                    w_id_pc_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IF_IDLE;
            end
        endcase
    end

    assign addr    = r_pc;
    assign id_ir   = r_id_ir;
    assign id_pc   = r_id_pc;
    assign halted  = (r_state == IF_HALT);
    assign running = (r_state == IF_RUN);

endmodule

`default_nettype wire
